// File: rtl/fe_fifo_reader_if.sv
// Byte-stream handshake carrying serialized event packets toward USB readout.
// The source drives byte and valid; the sink answers with ready.
interface fe_fifo_reader_if;
    logic [7:0] O_byte;
    logic       O_byte_valid;
    logic       I_byte_ready;

    modport master (output O_byte, output O_byte_valid, input I_byte_ready);
    modport slave  (input O_byte, input O_byte_valid, output I_byte_ready);
endinterface

// File: rtl/fe_fifo_reader.sv
// Drains the front-end capture FIFO, rebuilds absolute event time and
// serializes every non-reserved entry as a 4-byte packet for USB readout.
module fe_fifo_reader #(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pABS_TIME_WIDTH       = 32,
    parameter int pFIFO_WIDTH           = 2 + pTIMESTAMP_FULL_WIDTH + 8
) (
    input  logic                       usb_clk,
    input  logic                       reset_n,
    input  logic [pFIFO_WIDTH-1:0]     I_fifo_dout,
    input  logic                       I_fifo_empty,
    output logic                       O_fifo_rd,
    input  logic                       I_flush,
    fe_fifo_reader_if.master           byte_if,
    output logic                       O_event,
    output logic [pABS_TIME_WIDTH-1:0] O_event_time,
    output logic [7:0]                 O_event_data,
    output logic [pABS_TIME_WIDTH-1:0] O_abs_time,
    output logic [7:0]                 O_drop_count
);
    localparam int TW = pTIMESTAMP_FULL_WIDTH;

    localparam logic [1:0] CMD_DATA = 2'b00;
    localparam logic [1:0] CMD_TIME = 2'b10;
    localparam logic [1:0] CMD_RSVD = 2'b11;

    typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, SEND3} state_t;

    state_t                     state_reg, state_next;
    logic [pFIFO_WIDTH-1:0]     word_reg;
    logic [pABS_TIME_WIDTH-1:0] abs_time_reg;
    logic [pABS_TIME_WIDTH-1:0] event_time_reg;
    logic [7:0]                 event_data_reg;
    logic                       event_reg;
    logic [7:0]                 drop_count_reg;

    logic [1:0]                 head_cmd;
    logic [TW-1:0]              head_delta;
    logic [7:0]                 head_data;
    logic [pABS_TIME_WIDTH-1:0] head_delta_ext;
    logic [pABS_TIME_WIDTH-1:0] abs_time_sum;
    logic                       take;
    logic [15:0]                word_delta16;

    assign head_cmd   = I_fifo_dout[pFIFO_WIDTH-1 -: 2];
    assign head_delta = I_fifo_dout[pFIFO_WIDTH-3 -: TW];
    assign head_data  = I_fifo_dout[7:0];

    always_comb begin
        head_delta_ext         = '0;
        head_delta_ext[TW-1:0] = head_delta;
    end

    assign abs_time_sum = abs_time_reg + head_delta_ext;

    // Popping is held off while in reset so no FIFO entry is lost unseen.
    assign O_fifo_rd = reset_n && !I_fifo_empty && (I_flush || state_reg == IDLE);
    assign take      = O_fifo_rd && !I_flush;

    // State register
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (I_flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (take && head_cmd != CMD_RSVD) state_next = SEND0;
                SEND0:   if (byte_if.I_byte_ready) state_next = SEND1;
                SEND1:   if (byte_if.I_byte_ready) state_next = SEND2;
                SEND2:   if (byte_if.I_byte_ready) state_next = SEND3;
                SEND3:   if (byte_if.I_byte_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: latched word, time accumulation, event capture, drop counter
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            word_reg       <= '0;
            abs_time_reg   <= '0;
            event_reg      <= 1'b0;
            event_time_reg <= '0;
            event_data_reg <= '0;
            drop_count_reg <= '0;
        end else begin
            event_reg <= 1'b0;
            if (I_flush) begin
                abs_time_reg <= '0;
            end else if (take) begin
                word_reg <= I_fifo_dout;
                if (head_cmd == CMD_DATA || head_cmd == CMD_TIME) begin
                    abs_time_reg <= abs_time_sum;
                end
                if (head_cmd == CMD_DATA) begin
                    event_reg      <= 1'b1;
                    event_time_reg <= abs_time_sum;
                    event_data_reg <= head_data;
                end
                if (head_cmd == CMD_RSVD && drop_count_reg != 8'hFF) begin
                    drop_count_reg <= drop_count_reg + 8'd1;
                end
            end
        end
    end

    // Delta is zero-padded to 16 bits so narrower timestamps still fill bytes 1/2.
    always_comb begin
        word_delta16         = '0;
        word_delta16[TW-1:0] = word_reg[pFIFO_WIDTH-3 -: TW];
    end

    // Output logic
    always_comb begin
        byte_if.O_byte       = 8'h00;
        byte_if.O_byte_valid = 1'b0;
        case (state_reg)
            SEND0: begin
                byte_if.O_byte       = {word_reg[pFIFO_WIDTH-1 -: 2], 6'b0};
                byte_if.O_byte_valid = 1'b1;
            end
            SEND1: begin
                byte_if.O_byte       = word_delta16[15:8];
                byte_if.O_byte_valid = 1'b1;
            end
            SEND2: begin
                byte_if.O_byte       = word_delta16[7:0];
                byte_if.O_byte_valid = 1'b1;
            end
            SEND3: begin
                byte_if.O_byte       = word_reg[7:0];
                byte_if.O_byte_valid = 1'b1;
            end
            default: begin
                byte_if.O_byte       = 8'h00;
                byte_if.O_byte_valid = 1'b0;
            end
        endcase
    end

    assign O_event      = event_reg;
    assign O_event_time = event_time_reg;
    assign O_event_data = event_data_reg;
    assign O_abs_time   = abs_time_reg;
    assign O_drop_count = drop_count_reg;
endmodule
